stub_page_writer: RTL and testbench

STUB_PAGE_WRITER -- requirements
Module: stub_page_writer

---
 rtl/stub_page_writer_pkg.sv | 28 ++
 rtl/stub_page_writer.sv | 142 ++++++++++++++
 tb/tb_stub_page_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/stub_page_writer_pkg.sv
// Shared definitions for the stub page writer: width helper, FSM state
// encoding and default geometry.
package stub_page_writer_pkg;

    localparam int DEF_RAM_WIDTH = 12;
    localparam int DEF_RAM_DEPTH = 128;
    localparam int DEF_NPAGE     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    // Minimum one bit so a degenerate depth still yields a legal vector.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stub_page_writer.sv
// Writes incoming stub words into a paged reg_array, one page per event,
// and hands the last completed page and its entry count to the reader.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no event open since reset; din_valid ignored
// FILL  | event open, words written to {wr_page, count}
// FULL  | current page holds PAGE_DEPTH words; extra words dropped, ovf set
module stub_page_writer
    import stub_page_writer_pkg::*;
#(
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int NPAGE     = DEF_NPAGE
) (
    input  logic                                   clka,
    input  logic                                   rsta_n,
    input  logic                                   start,
    input  logic [RAM_WIDTH-1:0]                   din,
    input  logic                                   din_valid,
    output logic                                   wea,
    output logic [clogb2(RAM_DEPTH)-1:0]           addra,
    output logic [RAM_WIDTH-1:0]                   dina,
    output logic [clogb2(NPAGE)-1:0]               rd_page,
    output logic [clogb2(RAM_DEPTH/NPAGE):0]       nent,
    output logic                                   done,
    output logic                                   ovf
);

    localparam int PAGE_DEPTH = RAM_DEPTH / NPAGE;
    localparam int AW = clogb2(RAM_DEPTH);
    localparam int PW = clogb2(NPAGE);
    localparam int SW = clogb2(PAGE_DEPTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] PD = CW'(PAGE_DEPTH);

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_page_q, wr_page_d;
    logic [PW-1:0]       wr_page_nxt;
    logic [CW-1:0]       count_q, count_d;
    logic                wea_q, wea_d;
    logic [AW-1:0]       addra_q, addra_d;
    logic [RAM_WIDTH-1:0] dina_q, dina_d;
    logic [PW-1:0]       rd_page_q, rd_page_d;
    logic [CW-1:0]       nent_q, nent_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    assign wr_page_nxt = wr_page_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        wr_page_d = wr_page_q;
        count_d   = count_q;
        wea_d     = 1'b0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        rd_page_d = rd_page_q;
        nent_d    = nent_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    wr_page_d = '0;
                    count_d   = '0;
                end
            end
            FILL, FULL: begin
                if (start) begin
                    rd_page_d = wr_page_q;
                    nent_d    = count_q;
                    done_d    = 1'b1;
                    wr_page_d = wr_page_nxt;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    state_d   = FILL;
                    // A word arriving with start opens the new page at slot 0.
                    if (din_valid) begin
                        wea_d   = 1'b1;
                        addra_d = {wr_page_nxt, SW'(0)};
                        dina_d  = din;
                        count_d = CW'(1);
                    end
                    if (count_d == PD) begin
                        state_d = FULL;
                    end
                end else if (din_valid) begin
                    if (state_q == FILL) begin
                        wea_d   = 1'b1;
                        addra_d = {wr_page_q, count_q[SW-1:0]};
                        dina_d  = din;
                        count_d = count_q + CW'(1);
                        if (count_d == PD) begin
                            state_d = FULL;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q   <= IDLE;
            wr_page_q <= '0;
            count_q   <= '0;
            wea_q     <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            rd_page_q <= '0;
            nent_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_page_q <= wr_page_d;
            count_q   <= count_d;
            wea_q     <= wea_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            rd_page_q <= rd_page_d;
            nent_q    <= nent_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wea     = wea_q;
    assign addra   = addra_q;
    assign dina    = dina_q;
    assign rd_page = rd_page_q;
    assign nent    = nent_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_stub_page_writer.sv
// Scoreboard bench for stub_page_writer: directed stimulus pushes expected
// writes and page handoffs; a negedge monitor pops and compares them.
module tb_stub_page_writer;

    logic        clka;
    logic        rsta_n;
    logic        start;
    logic [11:0] din;
    logic        din_valid;
    logic        wea;
    logic [6:0]  addra;
    logic [11:0] dina;
    logic        rd_page;
    logic [6:0]  nent;
    logic        done;
    logic        ovf;

    typedef struct packed {
        logic [6:0]  addr;
        logic [11:0] data;
    } wr_t;

    typedef struct packed {
        logic       page;
        logic [6:0] n;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic       exp_rd_page = 1'b0;
    logic [6:0] exp_nent    = 7'd0;

    stub_page_writer dut (
        .clka      (clka),
        .rsta_n    (rsta_n),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .rd_page   (rd_page),
        .nent      (nent),
        .done      (done),
        .ovf       (ovf)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every DUT write / done pulse must match the head of its queue.
    always @(negedge clka) begin
        if (!rsta_n) begin
            exp_rd_page = 1'b0;
            exp_nent    = 7'd0;
        end else begin
            if (wea === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", {25'd0, addra}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("write_addr", {25'd0, addra}, {25'd0, e.addr});
                    chk("write_data", {20'd0, dina}, {20'd0, e.data});
                end
            end
            if (done === 1'b1) begin
                if (dn_q.size() == 0) begin
                    chk("unexpected_done_nent", {25'd0, nent}, 32'hFFFF_FFFF);
                end else begin
                    dn_t e;
                    e = dn_q.pop_front();
                    exp_rd_page = e.page;
                    exp_nent    = e.n;
                end
            end
            chk("rd_page", {31'd0, rd_page}, {31'd0, exp_rd_page});
            chk("nent", {25'd0, nent}, {25'd0, exp_nent});
        end
    end

    task automatic tick(input logic s, input logic v, input logic [11:0] d);
        start     = s;
        din_valid = v;
        din       = d;
        @(posedge clka);
        #1;
        start     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic exp_wr(input logic [6:0] a, input logic [11:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic exp_dn(input logic p, input logic [6:0] n);
        dn_t e;
        e.page = p;
        e.n    = n;
        dn_q.push_back(e);
    endtask

    task automatic do_reset();
        rsta_n = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        rsta_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wea"},     {31'd0, wea},     32'd0);
        chk({tag, "_addra"},   {25'd0, addra},   32'd0);
        chk({tag, "_dina"},    {20'd0, dina},    32'd0);
        chk({tag, "_rd_page"}, {31'd0, rd_page}, 32'd0);
        chk({tag, "_nent"},    {25'd0, nent},    32'd0);
        chk({tag, "_done"},    {31'd0, done},    32'd0);
        chk({tag, "_ovf"},     {31'd0, ovf},     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsta_n    = 1'b0;
        start     = 1'b0;
        din       = 12'h000;
        din_valid = 1'b0;
        #12;
        chk_zero("reset");
        @(posedge clka);
        #1;
        rsta_n = 1'b1;

        // Three words into page 0, then handoff of page 0 with 3 entries.
        tick(1'b1, 1'b0, 12'h000);
        exp_wr(7'd0, 12'h00A); tick(1'b0, 1'b1, 12'h00A);
        exp_wr(7'd1, 12'h00B); tick(1'b0, 1'b1, 12'h00B);
        exp_wr(7'd2, 12'h00C); tick(1'b0, 1'b1, 12'h00C);
        exp_dn(1'b0, 7'd3);    tick(1'b1, 1'b0, 12'h000);
        chk("t1_ovf", {31'd0, ovf}, 32'd0);

        // Page 1: two words, then start with a word in the same cycle.
        exp_wr(7'd64, 12'h0D0); tick(1'b0, 1'b1, 12'h0D0);
        exp_wr(7'd65, 12'h0D1); tick(1'b0, 1'b1, 12'h0D1);
        exp_dn(1'b1, 7'd2);
        exp_wr(7'd0, 12'h123);  tick(1'b1, 1'b1, 12'h123);
        exp_dn(1'b0, 7'd1);     tick(1'b1, 1'b0, 12'h000);
        repeat (2) tick(1'b0, 1'b0, 12'h000);

        // Overflow: 65 words into a 64-entry page.
        do_reset();
        tick(1'b1, 1'b0, 12'h000);
        for (int i = 0; i < 64; i++) begin
            exp_wr(7'(i), 12'h100 + 12'(i));
            tick(1'b0, 1'b1, 12'h100 + 12'(i));
        end
        chk("ovf_at_64", {31'd0, ovf}, 32'd0);
        tick(1'b0, 1'b1, 12'hFFF);
        chk("ovf_at_65", {31'd0, ovf}, 32'd1);
        tick(1'b0, 1'b0, 12'h000);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        exp_dn(1'b0, 7'd64); tick(1'b1, 1'b0, 12'h000);
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        repeat (2) tick(1'b0, 1'b0, 12'h000);

        // Three single-word events: pages 0,1,0 and page wrap.
        do_reset();
        tick(1'b1, 1'b0, 12'h000);
        exp_wr(7'd0, 12'h011);  tick(1'b0, 1'b1, 12'h011);
        exp_dn(1'b0, 7'd1);     tick(1'b1, 1'b0, 12'h000);
        exp_wr(7'd64, 12'h022); tick(1'b0, 1'b1, 12'h022);
        exp_dn(1'b1, 7'd1);     tick(1'b1, 1'b0, 12'h000);
        exp_wr(7'd0, 12'h033);  tick(1'b0, 1'b1, 12'h033);

        // Asynchronous reset mid-event after 5 more words.
        for (int i = 0; i < 5; i++) begin
            exp_wr(7'(i + 1), 12'h0E1 + 12'(i));
            tick(1'b0, 1'b1, 12'h0E1 + 12'(i));
        end
        @(negedge clka);
        #1;
        rsta_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clka);
        #1;
        @(posedge clka);
        #1;
        rsta_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1, 12'h0AA);
        tick(1'b1, 1'b0, 12'h000);
        exp_wr(7'd0, 12'h0F0); tick(1'b0, 1'b1, 12'h0F0);
        exp_dn(1'b0, 7'd1);    tick(1'b1, 1'b0, 12'h000);
        repeat (3) tick(1'b0, 1'b0, 12'h000);

        chk("writes_outstanding", wr_q.size(), 32'd0);
        chk("done_outstanding", dn_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
